full_adder_core: RTL and testbench
==================================

# full_adder_core

Combinational full adder with a registered copy of its result, used as the arithmetic leaf cell of the datapath. Adds two operands and a carry-in. Drives `sum`/`carry` combinationally for same-cycle consumers, and a flopped, valid-qualified copy for pipelined consumers. `WIDTH` = 1 gives the classic single-bit full adder; wider values build a ripple-carry adder from the same bit cell.

## Interface
Parameters:
- `WIDTH`, default 1: operand width in bits; legal range 1–64.

Ports:
- `clk` input 1: single clock; all flops are rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `a` input WIDTH: operand A, unsigned.
- `b` input WIDTH: operand B, unsigned.
- `cin` input 1: carry-in.
- `in_valid` input 1: qualifies `a`/`b`/`cin` for the registered path.
- `sum` output WIDTH: combinational sum bits.
- `carry` output 1: combinational carry-out.
- `sum_q` output WIDTH: registered `sum`.
- `carry_q` output 1: registered `carry`.
- `out_valid` output 1: `sum_q`/`carry_q` hold a result captured from a valid input.

## Operation
- Arithmetic:
  - {`carry`, `sum`} = `a` + `b` + `cin`, computed at WIDTH+1 bits. No truncation or overflow loss.
  - Per bit i: s_i = a_i ^ b_i ^ c_i; c_{i+1} = a_i&b_i | a_i&c_i | b_i&c_i; c_0 = `cin`; `carry` = c_WIDTH.
- For WIDTH=1 the truth table is mandatory:
  - 000→s0 c0; 001/010/100→s1 c0; 011/101/110→s0 c1; 111→s1 c1.
- Combinational outputs:
  - Depend only on `a`, `b`, `cin`.
  - Independent of `clk`, `rst_n` and `in_valid`.
  - Valid even while reset is asserted.
- Registered path, on a rising `clk` with `rst_n` high:
  - If `in_valid`=1: `sum_q`←`sum`, `carry_q`←`carry`, `out_valid`←1.
  - If `in_valid`=0: `sum_q`/`carry_q` hold their value; `out_valid`←0.
- X/Z on inputs propagate per standard operators. No X-scrubbing.

## Timing
- Combinational path: zero-cycle latency. Outputs settle before any sample taken ≥1 ns after an input change.
- Registered path: latency is 1 cycle, from `in_valid` sampled high to `out_valid` high with the matching result.
- Throughput: one result per cycle. No backpressure; results are never stalled or dropped.
- Reset values, applied immediately on `rst_n` falling with no clock needed: `sum_q`=0, `carry_q`=0, `out_valid`=0.
- Reset release: the first capture happens on the first rising `clk` after `rst_n` goes high. The edge coincident with release must not capture.
- Reset asserted mid-stream: any in-flight result is discarded and `out_valid` drops to 0 at once.
- The combinational outputs are unaffected by reset.
- Boundary cases:
  - All-ones operands with `cin`=1 give `sum` = all ones and `carry`=1 (maximum value 2^(WIDTH+1)−1).
  - All zeros with `cin`=0 gives zero.

## Structure
- One sub-module, `full_adder_bit`:
  - Purely combinational; inputs a, b, ci; outputs s, co.
  - Instantiated WIDTH times in a generate loop, carry chained LSB→MSB.
- Top level holds the carry chain, the output register bank and the valid flop.
- Shared package `full_adder_pkg`:
  - `FA_MAX_WIDTH` = 64, used for the parameter range check (elaboration-time assertion).
  - `fa_result_t` packed struct {carry, sum} for consumers of the registered output.

## Test plan
- Exhaustive, WIDTH=1: all 8 combinations of `a`/`b`/`cin`, sampled 1 ns after each change. Check each against the truth table, e.g. 1,1,1 → `sum`=1, `carry`=1; 0,1,0 → 1, 0.
- Random, WIDTH=1: 50 random vectors, spaced 11 ns apart, each checked against `a`+`b`+`cin` with zero mismatches.
- Registered latency: `in_valid`=1 with a=1, b=1, cin=0 → one cycle later `sum_q`=0, `carry_q`=1, `out_valid`=1. Then drop `in_valid` → `out_valid`=0 and `sum_q`/`carry_q` hold.
- Async reset: pull `rst_n` low between clock edges while `out_valid`=1 → `sum_q`, `carry_q` and `out_valid` go to 0 immediately. The combinational `sum`/`carry` still track the inputs.
- Wide ripple, WIDTH=8: a=8'hFF, b=8'h00, cin=1 → `sum`=8'h00, `carry`=1. Also a=8'h5A, b=8'hA5, cin=0 → `sum`=8'hFF, `carry`=0.

Source files
------------

// File: rtl/full_adder_pkg.sv
// Shared constants and result type for the full-adder leaf cell and its consumers.
package full_adder_pkg;

  localparam int FA_MAX_WIDTH = 64;

  // Registered result as seen by downstream pipeline stages; sum is sized for the widest legal adder.
  typedef struct packed {
    logic                    carry;
    logic [FA_MAX_WIDTH-1:0] sum;
  } fa_result_t;

endpackage

// File: rtl/full_adder_bit.sv
// Single-bit full adder cell; purely combinational.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/full_adder_core.sv
// Ripple-carry adder built from full_adder_bit cells, with a valid-qualified registered copy of the result.
module full_adder_core
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_q,
  output logic             out_valid
);

  if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_width_chk
    $error("full_adder_core: WIDTH=%0d outside 1..%0d", WIDTH, FA_MAX_WIDTH);
  end

  // c[i] is the carry into bit i; c[WIDTH] is the carry-out.
  logic [WIDTH:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_bit u_bit (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  assign carry = c[WIDTH];

  // Result registers hold on idle cycles; only the valid flag is cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q     <= '0;
      carry_q   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum_q   <= sum;
        carry_q <= carry;
      end
    end
  end

endmodule

// File: tb/tb_full_adder_core.sv
// Randomized bench for full_adder_core at WIDTH=1 and WIDTH=8 against an arithmetic reference model.
module tb_full_adder_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cin, in_valid;
  logic       a1, b1;
  logic [7:0] a8, b8;

  logic       s1, c1, s1q, c1q, v1;
  logic [7:0] s8, s8q;
  logic       c8, c8q, v8;

  // Reference state for the registered path: {carry, sum} and the valid flag.
  logic [1:0] m1_q;
  logic [8:0] m8_q;
  logic       m_v;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  full_adder_core #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin), .in_valid(in_valid),
    .sum(s1), .carry(c1), .sum_q(s1q), .carry_q(c1q), .out_valid(v1)
  );

  full_adder_core #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin), .in_valid(in_valid),
    .sum(s8), .carry(c8), .sum_q(s8q), .carry_q(c8q), .out_valid(v8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic comb_check(input string tag);
    logic [1:0] r1;
    logic [8:0] r8;
    r1 = a1 + b1 + cin;
    r8 = a8 + b8 + cin;
    chk({tag, "_c1"}, {c1, s1}, r1);
    chk({tag, "_c8"}, {c8, s8}, r8);
  endtask

  task automatic reg_check(input string tag);
    chk({tag, "_r1"}, {c1q, s1q}, m1_q);
    chk({tag, "_r8"}, {c8q, s8q}, m8_q);
    chk({tag, "_v1"}, v1, m_v);
    chk({tag, "_v8"}, v8, m_v);
  endtask

  // Drive one cycle of inputs, check comb outputs, then check registers after the next edge.
  task automatic step(input logic ia1, ib1, input logic [7:0] ia8, ib8,
                      input logic ic, iv, input string tag);
    a1 = ia1; b1 = ib1; a8 = ia8; b8 = ib8; cin = ic; in_valid = iv;
    #1 comb_check(tag);
    @(posedge clk);
    if (!rst_n) begin
      m1_q = '0; m8_q = '0; m_v = 1'b0;
    end else begin
      if (iv) begin
        m1_q = a1 + b1 + cin;
        m8_q = a8 + b8 + cin;
      end
      m_v = iv;
    end
    #1 reg_check(tag);
  endtask

  initial begin
    logic [7:0] tt_s, tt_c;
    logic [2:0] n;
    tt_s = 8'b1001_0110;
    tt_c = 8'b1110_1000;
    m1_q = '0; m8_q = '0; m_v = 1'b0;

    rst_n = 1'b0; in_valid = 1'b0;
    a1 = 1'b1; b1 = 1'b0; cin = 1'b1; a8 = 8'h3C; b8 = 8'hC4;
    #1;
    reg_check("rst");
    comb_check("rst_comb");
    #2 rst_n = 1'b1;

    // Exhaustive single-bit truth table, each vector also captured.
    for (int i = 0; i < 8; i++) begin
      n = i[2:0];
      step(n[2], n[1], 8'($urandom), 8'($urandom), n[0], 1'b1, "exh");
      chk("tt_s", s1, tt_s[i]);
      chk("tt_c", c1, tt_c[i]);
    end

    step(1'b1, 1'b1, 8'h01, 8'h01, 1'b0, 1'b1, "lat");
    chk("lat_sq", {c1q, s1q, v1}, 3'b101);
    step(1'b0, 1'b0, 8'h10, 8'h20, 1'b1, 1'b0, "hold");
    chk("hold_sq", {c1q, s1q, v1}, 3'b100);

    // Unclocked random vectors on the combinational path.
    in_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      a1 = 1'($urandom); b1 = 1'($urandom); cin = 1'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom);
      #1 comb_check("rnd");
      #10;
    end
    @(posedge clk);
    m_v = 1'b0;
    #1 reg_check("rnd_end");

    for (int i = 0; i < 40; i++)
      step(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
           1'($urandom), 1'($urandom_range(0, 3) != 0), "rstep");

    // Asynchronous reset between edges while a valid result is held.
    step(1'b1, 1'b1, 8'hFF, 8'h01, 1'b1, 1'b1, "pre_rst");
    #3 rst_n = 1'b0;
    m1_q = '0; m8_q = '0; m_v = 1'b0;
    #1 reg_check("async_rst");
    comb_check("rst_track0");
    a1 = 1'b1; b1 = 1'b0; a8 = 8'h80; b8 = 8'h80; cin = 1'b0;
    #1 comb_check("rst_track1");
    step(1'b1, 1'b1, 8'hAA, 8'h55, 1'b1, 1'b1, "in_rst");
    rst_n = 1'b1;
    step(1'b0, 1'b1, 8'h12, 8'h34, 1'b1, 1'b1, "post_rst");

    // Wide boundaries.
    step(1'b1, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b1, "w_ff00");
    chk("w_ff00_k", {c8, s8}, 9'h100);
    step(1'b0, 1'b0, 8'h5A, 8'hA5, 1'b0, 1'b1, "w_5aa5");
    chk("w_5aa5_k", {c8, s8}, 9'h0FF);
    step(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, "w_max");
    chk("w_max_k", {c8, s8}, 9'h1FF);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, "w_zero");
    chk("w_zero_k", {c8, s8}, 9'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
